serial_add_sub: RTL and testbench

Bit-serial add/subtract unit, the sequential counterpart of the four-bit ripple adder. It processes one bit position per clock through a single full-adder slice. The module accepts two WIDTH-bit operands and a mode bit on a start pulse, then returns the sum or difference with carry-out, carry-into-MSB and signed overflow. It is used where area matters more than latency, and as the subtract path beside the existing combinational adder.

---
 rtl/serial_add_sub_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_add_sub.sv | 113 +++++++++++
 tb/tb_serial_add_sub.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_sub_pkg.sv
// Shared types for the bit-serial add/subtract unit: FSM states, default width, index sizing.
package add_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int idx_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial slice; purely combinational, no backpressure.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial A+B / A-B, one bit per clock; done pulses WIDTH+1 cycles after an accepted start, start ignored while busy.
// Define SERIAL_ADD_SUB_OVF_EN to build the carry-into-MSB capture and signed overflow output.
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             C3,
  output logic             V
);

  localparam int IW = idx_w(WIDTH);

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             sum_d;
  logic             carry_d;
  logic             last_bit;

  assign last_bit = (idx_q == IW'(WIDTH - 1));

  full_adder u_slice (
    .A    (a_q[idx_q]),
    .B    (b_q[idx_q]),
    .Cin  (carry_q),
    .S    (sum_d),
    .Cout (carry_d)
  );

  // B is stored pre-inverted and the carry seeded with sub, so subtraction is A + ~B + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= A;
            b_q     <= B ^ {WIDTH{sub}};
            carry_q <= sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          s_q[idx_q] <= sum_d;
          carry_q    <= carry_d;
          idx_q      <= idx_q + IW'(1);
          if (last_bit) begin
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_SUB_OVF_EN
  logic c3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c3_q <= 1'b0;
    end else if (state_q == RUN && last_bit) begin
      c3_q <= carry_q;
    end
  end

  assign C3 = c3_q;
  assign V  = c3_q ^ cout_q;
`else
  assign C3 = 1'b0;
  assign V  = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboarded bench for serial_add_sub: directed corner cases, reset abort, then random operations.
module tb_serial_add_sub;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  typedef struct {
    int s;
    bit cout;
    bit c3;
    bit v;
    int done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, cout, C3, V;
  logic [W-1:0] S;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t q[$];

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .A(A), .B(B),
    .busy(busy), .done(done), .S(S), .cout(cout), .C3(C3), .V(V)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: unsigned arithmetic for S/cout, signed range check for V, C3 recovered as V^cout.
  function automatic exp_t model(input int a, input int b, input bit op_sub);
    exp_t e;
    int   sa, sb, sr;
    sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
    sr = op_sub ? sa - sb : sa + sb;
    e.s    = (op_sub ? a - b : a + b) & MASK;
    e.cout = op_sub ? (a >= b) : ((a + b) > MASK);
`ifdef SERIAL_ADD_SUB_OVF_EN
    e.v  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    e.c3 = e.v ^ e.cout;
`else
    e.v  = 1'b0;
    e.c3 = 1'b0;
`endif
    e.done_cyc = 0;
    return e;
  endfunction

  // Called at a negedge with the DUT not busy; the start is taken on the next posedge.
  task automatic launch(input int a, input int b, input bit op_sub);
    exp_t e;
    e = model(a, b, op_sub);
    e.done_cyc = cyc + 1 + W;
    q.push_back(e);
    start = 1'b1;
    A     = W'(a);
    B     = W'(b);
    sub   = op_sub;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q.size() != 0 || busy || done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: queue=%0d busy=%0b expected idle", q.size(), busy);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: done=%0b expected 1", done);
    end
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: busy=%0b expected 0", busy);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy && done) begin
      checks++;
      errors++;
      $display("FAIL busy_done_overlap: busy=1 done=1 expected not both");
    end
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("S", int'(S), e.s);
        chk("cout", int'(cout), int'(e.cout));
        chk("C3", int'(C3), int'(e.c3));
        chk("V", int'(V), int'(e.v));
        chk("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  initial begin
    int a, b, gap;
    bit op;

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_S", int'(S), 0);
    chk("rst_cout", int'(cout), 0);
    chk("rst_C3", int'(C3), 0);
    chk("rst_V", int'(V), 0);
    rst = 1'b0;
    @(negedge clk);

    launch(5, 3, 1'b1);
    wait_drain();
    launch(3, 5, 1'b0);
    wait_drain();
    launch(7, 8, 1'b1);
    wait_drain();

    // Back-to-back: the second start lands in the DONE cycle of the first.
    launch(15, 1, 1'b0);
    wait_done();
    launch(2, 2, 1'b0);
    wait_drain();

    // Starts with different operands while RUN must be ignored.
    launch(6, 1, 1'b0);
    start = 1'b1; A = 4'd9; B = 4'd9; sub = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Abort on the third RUN cycle: no done, outputs back to reset values.
    start = 1'b1; A = 4'd4; B = 4'd1; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_S", int'(S), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_cout", int'(cout), 0);
    rst = 1'b0;
    repeat (W + 3) @(negedge clk);
    launch(4, 1, 1'b0);
    wait_drain();

    for (int i = 0; i < 40; i++) begin
      wait_not_busy();
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      a  = $urandom_range(0, MASK);
      b  = $urandom_range(0, MASK);
      op = 1'($urandom_range(0, 1));
      launch(a, b, op);
    end
    wait_drain();
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
